// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential unsigned fixed-point divider. Computes
//     Q = floor(A * 2^FRAC / B),  R = (A * 2^FRAC) mod B
//   with a restoring shift-subtract loop that produces one quotient bit per
//   clock, N = WIDTH + FRAC iterations per division.
//
// Ports
//   clk    in   1      rising-edge clock
//   sclr   in   1      synchronous active-high clear (priority over all)
//   start  in   1      division request, only looked at while idle
//   in_A   in   WIDTH  unsigned dividend, captured on the accepting edge
//   in_B   in   WIDTH  unsigned divisor, captured on the accepting edge
//   busy   out  1      high while the iteration loop runs
//   done   out  1      one-cycle pulse when a result (or dvz) is ready
//   q_out  out  WIDTH  quotient, FRAC fractional bits, saturated on overflow
//   r_out  out  WIDTH  integer remainder
//   dvz    out  1      last operation was a divide by zero
//   ovf    out  1      last quotient did not fit WIDTH bits
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             start,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out,
  output logic             dvz,
  output logic             ovf
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Registers
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_p;      // partial remainder
  logic [N-1:0]     r_q;      // dividend bits shifting out, quotient bits in
  logic [WIDTH-1:0] r_b;      // captured divisor
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_r_out;
  logic             r_dvz;
  logic             r_ovf;

  // Next-state values
  state_t           w_state_next;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH:0]   w_p_next;
  logic [N-1:0]     w_q_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_q_out_next;
  logic [WIDTH-1:0] w_r_out_next;
  logic             w_dvz_next;
  logic             w_ovf_next;

  // One restoring iteration
  logic [WIDTH:0]   w_shift_p;
  logic             w_ge;
  logic [WIDTH:0]   w_p_step;
  logic [N-1:0]     w_q_step;
  logic [N-1:0]     w_dividend;
  logic             w_q_hi_nz;

  // {P, Q} << 1. The bit shifted out of P's MSB is folded into the compare:
  // if it was set, the shifted value is at least 2^(WIDTH+1) > B, and the
  // modular WIDTH+1-bit subtraction still yields the correct (< B) remainder.
  assign w_shift_p = {r_p[WIDTH-1:0], r_q[N-1]};
  assign w_ge      = r_p[WIDTH] | (w_shift_p >= {1'b0, r_b});
  assign w_p_step  = w_ge ? (w_shift_p - {1'b0, r_b}) : w_shift_p;
  assign w_q_step  = {r_q[N-2:0], w_ge};

  generate
    if (FRAC > 0) begin : g_frac
      // A * 2^FRAC: dividend in the upper WIDTH bits, zeros below
      assign w_dividend = {in_A, {FRAC{1'b0}}};
      // Any set bit above the low WIDTH bits of Q means overflow
      assign w_q_hi_nz  = |w_q_step[N-1:WIDTH];
    end else begin : g_nofrac
      assign w_dividend = in_A;
      assign w_q_hi_nz  = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_p_next     = r_p;
    w_q_next     = r_q;
    w_b_next     = r_b;
    w_q_out_next = r_q_out;
    w_r_out_next = r_r_out;
    w_dvz_next   = r_dvz;
    w_ovf_next   = r_ovf;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (in_B != '0) begin
            w_state_next = S_CALC;
            w_cnt_next   = '0;
            w_p_next     = '0;
            w_q_next     = w_dividend;
            w_b_next     = in_B;
            w_dvz_next   = 1'b0;
            w_ovf_next   = 1'b0;
          end else begin
            // Divide by zero: skip the loop and report immediately
            w_state_next = S_DONE;
            w_dvz_next   = 1'b1;
            w_ovf_next   = 1'b0;
            w_q_out_next = '0;
            w_r_out_next = '0;
          end
        end
      end

      S_CALC: begin
        w_p_next   = w_p_step;
        w_q_next   = w_q_step;
        w_cnt_next = r_cnt + CW'(1);
        if (r_cnt == CW'(N - 1)) begin
          // Last iteration: publish the result as DONE is entered
          w_state_next = S_DONE;
          w_ovf_next   = w_q_hi_nz;
          w_q_out_next = w_q_hi_nz ? '1 : w_q_step[WIDTH-1:0];
          w_r_out_next = w_p_step[WIDTH-1:0];
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dvz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_p     <= w_p_next;
      r_q     <= w_q_next;
      r_b     <= w_b_next;
      r_q_out <= w_q_out_next;
      r_r_out <= w_r_out_next;
      r_dvz   <= w_dvz_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign busy  = (r_state == S_CALC);
  assign done  = (r_state == S_DONE);
  assign q_out = r_q_out;
  assign r_out = r_r_out;
  assign dvz   = r_dvz;
  assign ovf   = r_ovf;

endmodule
